// File: rtl/group_pkg.sv
// Shared width helpers and saturation bounds for the MAC group result drain.
package group_pkg;

  localparam int unsigned DEF_GROUP_NB  = 4;
  localparam int unsigned DEF_IMG_WIDTH = 16;
  localparam int unsigned DEF_KER_WIDTH = 16;
  localparam int unsigned DEF_OUT_WIDTH = 16;
  localparam int unsigned DEF_SHIFT     = 8;

  // Accumulator width: full product plus one guard bit for accumulation sign.
  function automatic int unsigned res_width(input int unsigned img_w, input int unsigned ker_w);
    return img_w + ker_w + 1;
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return (w == 0) ? 1 : w;
  endfunction

  function automatic longint sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/group_result_drain_round_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation.
module round_sat
  import group_pkg::*;
#(
  parameter int unsigned RES_W     = 33,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned SHIFT     = 8
) (
  input  logic signed [RES_W-1:0]     din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam int unsigned EXT_W = RES_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(sat_max(OUT_WIDTH));
  localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(sat_min(OUT_WIDTH));

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] shifted;

  // One extra bit keeps the rounding add from wrapping at the positive limit.
  assign ext = EXT_W'(din);

  generate
    if (SHIFT == 0) begin : g_noshift
      assign shifted = ext;
    end else begin : g_shift
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(longint'(1) <<< (SHIFT - 1));
      assign shifted = (ext + HALF) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    dout = OUT_WIDTH'(shifted);
    if (shifted > MAX_V)      dout = OUT_WIDTH'(MAX_V);
    else if (shifted < MIN_V) dout = OUT_WIDTH'(MIN_V);
  end

endmodule

// File: rtl/group_result_drain.sv
// Captures GROUP_NB MAC results into a ping-pong buffer and streams them out
// one rounded/saturated element per valid/ready transfer.
module group_result_drain
  import group_pkg::*;
#(
  parameter  int unsigned GROUP_NB  = DEF_GROUP_NB,
  parameter  int unsigned IMG_WIDTH = DEF_IMG_WIDTH,
  parameter  int unsigned KER_WIDTH = DEF_KER_WIDTH,
  parameter  int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter  int unsigned SHIFT     = DEF_SHIFT,
  localparam int unsigned RES_W     = res_width(IMG_WIDTH, KER_WIDTH),
  localparam int unsigned IDX_W     = clog2_min1(GROUP_NB)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GROUP_NB*RES_W-1:0] res,
  input  logic                      res_val,
  output logic                      res_rdy,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_NB - 1);

  logic signed [RES_W-1:0] bank [2][GROUP_NB];

  logic [1:0]       count, count_nxt;
  logic             wr_ptr, wr_ptr_nxt;
  logic             rd_ptr, rd_ptr_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             ovf_nxt;

  logic                        cap, drop, xfer, last_xfer;
  logic signed [RES_W-1:0]     rd_elem;
  logic signed [OUT_WIDTH-1:0] conv;

  // Handshake qualifiers, all derived from registered state.
  assign cap       = res_val & (count != 2'd2);
  assign drop      = res_val & (count == 2'd2);
  assign xfer      = (count != 2'd0) & out_rdy;
  assign last_xfer = xfer & (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= '0;
      ovf    <= 1'b0;
    end else begin
      count  <= count_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      idx    <= idx_nxt;
      ovf    <= ovf_nxt;
    end
  end

  // Bank storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int i = 0; i < int'(GROUP_NB); i++) begin
        bank[wr_ptr][i] <= res[i*RES_W +: RES_W];
      end
    end
  end

  // Next-state logic
  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    idx_nxt    = idx;
    ovf_nxt    = ovf;

    if (cap) wr_ptr_nxt = ~wr_ptr;

    if (xfer) begin
      if (idx == LAST_IDX) begin
        idx_nxt    = '0;
        rd_ptr_nxt = ~rd_ptr;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end

    unique case ({cap, last_xfer})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         ovf_nxt = 1'b1;
    else if (ovf_clr) ovf_nxt = 1'b0;
  end

  assign rd_elem = bank[rd_ptr][idx];

  round_sat #(
    .RES_W     (RES_W),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_round_sat (
    .din  (rd_elem),
    .dout (conv)
  );

  // Output decode
  always_comb begin
    res_rdy  = (count != 2'd2);
    out_val  = (count != 2'd0);
    out_idx  = idx;
    out_last = 1'b0;
    out_data = '0;
    if (count != 2'd0) begin
      out_last = (idx == LAST_IDX);
      out_data = OUT_WIDTH'(conv);
    end
  end

endmodule

// File: tb/tb_group_result_drain.sv
// Self-checking bench: queue-based reference model with randomized traffic,
// plus a single-element SHIFT=0 instance for directed saturation checks.
module tb_group_result_drain;

  localparam int unsigned G  = 4;
  localparam int unsigned OW = 16;
  localparam int unsigned SH = 8;
  localparam int unsigned RW = 16 + 16 + 1;
  localparam int unsigned XW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [G*RW-1:0] res;
  logic            res_val, res_rdy, out_last, out_val, out_rdy, ovf, ovf_clr;
  logic [OW-1:0]   out_data;
  logic [XW-1:0]   out_idx;

  logic [RW-1:0]   res1;
  logic            res1_val, res1_rdy, out1_last, out1_val, out1_rdy, ovf1, ovf1_clr;
  logic [OW-1:0]   out1_data;
  logic [0:0]      out1_idx;

  int checks = 0;
  int failures = 0;

  longint cv [G];
  longint mq [$];
  int     midx;
  bit     movf;

  always #5 clk = ~clk;

  group_result_drain #(.GROUP_NB(G), .IMG_WIDTH(16), .KER_WIDTH(16), .OUT_WIDTH(OW), .SHIFT(SH)) u_dut (
    .clk(clk), .rst(rst), .res(res), .res_val(res_val), .res_rdy(res_rdy),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_val(out_val),
    .out_rdy(out_rdy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  group_result_drain #(.GROUP_NB(1), .IMG_WIDTH(16), .KER_WIDTH(16), .OUT_WIDTH(OW), .SHIFT(0)) u_dut1 (
    .clk(clk), .rst(rst), .res(res1), .res_val(res1_val), .res_rdy(res1_rdy),
    .out_data(out1_data), .out_idx(out1_idx), .out_last(out1_last), .out_val(out1_val),
    .out_rdy(out1_rdy), .ovf(ovf1), .ovf_clr(ovf1_clr)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_conv(input longint v, input int sh, input int ow);
    longint r, hi, lo;
    r  = v;
    if (sh > 0) r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  function automatic longint rand_res();
    logic [RW-1:0] r;
    case ($urandom_range(0, 2))
      0:       r = RW'({$urandom, $urandom});
      1:       r = RW'(longint'($urandom_range(0, 20000000)) - 64'sd10000000);
      default: r = RW'(longint'($urandom_range(0, 600)) - 64'sd300);
    endcase
    return longint'($signed(r));
  endfunction

  // Expected outputs follow from how many whole groups are queued and which one is at the head.
  task automatic check_outputs(input string ph);
    bit     v;
    longint d;
    v = (mq.size() != 0);
    d = v ? ref_conv(mq[midx], int'(SH), int'(OW)) : 64'sd0;
    chk({ph, "_val"},  longint'(out_val), longint'(v));
    chk({ph, "_rdy"},  longint'(res_rdy), longint'(mq.size() < 2 * G));
    chk({ph, "_idx"},  longint'(out_idx), longint'(midx));
    chk({ph, "_last"}, longint'(out_last), longint'(v && midx == int'(G) - 1));
    chk({ph, "_data"}, longint'($signed(out_data)), d);
    chk({ph, "_ovf"},  longint'(ovf), longint'(movf));
  endtask

  task automatic model_step(input bit v, input bit rdy, input bit clr);
    bit room;
    room = (mq.size() < 2 * G);
    if (mq.size() != 0 && rdy) begin
      if (midx == int'(G) - 1) begin
        for (int i = 0; i < int'(G); i++) void'(mq.pop_front());
        midx = 0;
      end else begin
        midx++;
      end
    end
    if (v && room) for (int i = 0; i < int'(G); i++) mq.push_back(cv[i]);
    if (v && !room) movf = 1'b1;
    else if (clr)   movf = 1'b0;
  endtask

  // Called at a negedge: drive, clock, update model, check at the next negedge.
  task automatic do_cycle(input bit v, input bit rdy, input bit clr, input string ph);
    res_val = v;
    out_rdy = rdy;
    ovf_clr = clr;
    for (int i = 0; i < int'(G); i++) res[i*RW +: RW] = RW'(cv[i]);
    @(posedge clk);
    model_step(v, rdy, clr);
    @(negedge clk);
    check_outputs(ph);
    res_val = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic rand_group();
    for (int i = 0; i < int'(G); i++) cv[i] = rand_res();
  endtask

  initial begin
    longint n5;
    rst = 1'b0; res = '0; res_val = 1'b0; out_rdy = 1'b0; ovf_clr = 1'b0;
    res1 = '0; res1_val = 1'b0; out1_rdy = 1'b0; ovf1_clr = 1'b0;
    mq.delete(); midx = 0; movf = 1'b0;
    for (int i = 0; i < int'(G); i++) cv[i] = 0;

    #1;
    check_outputs("reset");
    chk("reset1_rdy", longint'(res1_rdy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single-element instance, no shift: saturation and pass-through.
    res1 = RW'(64'sd40000); res1_val = 1'b1;
    @(negedge clk);
    res1_val = 1'b0;
    chk("g1_val", longint'(out1_val), 1);
    chk("g1_sat", longint'($signed(out1_data)), 32767);
    chk("g1_last", longint'(out1_last), 1);
    chk("g1_idx", longint'(out1_idx), 0);
    out1_rdy = 1'b1;
    @(negedge clk);
    chk("g1_empty", longint'(out1_val), 0);
    n5 = -5;
    res1 = RW'(n5); res1_val = 1'b1;
    @(negedge clk);
    res1_val = 1'b0;
    chk("g1_neg", longint'($signed(out1_data)), -5);
    chk("g1_neg_last", longint'(out1_last), 1);
    @(negedge clk);
    chk("g1_drained", longint'(out1_val), 0);

    // Single capture with known values, free-running drain.
    cv[0] = 4736; cv[1] = -384; cv[2] = longint'(1) <<< 24; cv[3] = -(longint'(1) <<< 24);
    do_cycle(1, 1, 0, "single_cap");
    chk("single_b0", longint'($signed(out_data)), 19);
    do_cycle(0, 1, 0, "single");
    chk("single_b1", longint'($signed(out_data)), -1);
    do_cycle(0, 1, 0, "single");
    chk("single_b2", longint'($signed(out_data)), 32767);
    do_cycle(0, 1, 0, "single");
    chk("single_b3", longint'($signed(out_data)), -32768);
    chk("single_b3_last", longint'(out_last), 1);
    do_cycle(0, 1, 0, "single_end");

    // Back-pressure pattern 1,0,0,1,...
    rand_group();
    do_cycle(1, 0, 0, "bp_cap");
    for (int k = 0; k < 14; k++) do_cycle(0, (k % 3) == 0, 0, "bp");

    // Overflow: three captures while stalled, then drain and clear.
    rand_group(); do_cycle(1, 0, 0, "ovf_c0");
    rand_group(); do_cycle(1, 0, 0, "ovf_c1");
    chk("ovf_full_rdy", longint'(res_rdy), 0);
    rand_group(); do_cycle(1, 0, 0, "ovf_c2");
    chk("ovf_set", longint'(ovf), 1);
    for (int k = 0; k < 8; k++) do_cycle(0, 1, 0, "ovf_drain");
    do_cycle(0, 1, 1, "ovf_clr");
    chk("ovf_cleared", longint'(ovf), 0);

    // Capture coincident with last-element transfer at count=1.
    rand_group(); do_cycle(1, 1, 0, "coin_cap");
    for (int k = 0; k < 3; k++) do_cycle(0, 1, 0, "coin");
    rand_group(); do_cycle(1, 1, 0, "coin_hit");
    chk("coin_nobubble_val", longint'(out_val), 1);
    chk("coin_nobubble_idx", longint'(out_idx), 0);
    chk("coin_nobubble_data", longint'($signed(out_data)), ref_conv(cv[0], int'(SH), int'(OW)));
    for (int k = 0; k < 4; k++) do_cycle(0, 1, 0, "coin_drain");

    // Mid-stream asynchronous reset at idx=2, count=2, ovf set.
    rand_group(); do_cycle(1, 0, 0, "mrst_c0");
    rand_group(); do_cycle(1, 0, 0, "mrst_c1");
    rand_group(); do_cycle(1, 0, 0, "mrst_c2");
    do_cycle(0, 1, 0, "mrst_x");
    do_cycle(0, 1, 0, "mrst_x");
    chk("mrst_idx_pre", longint'(out_idx), 2);
    out_rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    mq.delete(); midx = 0; movf = 1'b0;
    check_outputs("mrst_async");
    @(negedge clk);
    rst = 1'b1;
    rand_group(); do_cycle(1, 1, 0, "mrst_after");
    chk("mrst_after_idx", longint'(out_idx), 0);
    for (int k = 0; k < 4; k++) do_cycle(0, 1, 0, "mrst_drain");

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      rand_group();
      do_cycle($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 8, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/group_result_drain.md
Name: group_result_drain

Overview:
Drain side of the MAC group. It captures the GROUP_NB parallel accumulator results from the MAC group when the sequencer pulses a capture strobe, and holds them in a two-bank ping-pong buffer. It then streams them out one element per transfer over a valid/ready interface toward the output writer. Each element is rounded, right-shifted and saturated to OUT_WIDTH on the way out.

Parameters:
GROUP_NB, 4, number of MAC results per capture
IMG_WIDTH, 16, image operand width
KER_WIDTH, 16, kernel operand width; result width RES_W = IMG_WIDTH+KER_WIDTH+1
OUT_WIDTH, 16, signed output element width
SHIFT, 8, fixed-point arithmetic right shift applied to each result (0 allowed)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
res  in  GROUP_NB*RES_W  packed signed results, element i at [i*RES_W +: RES_W]
res_val  in  1  single-cycle capture strobe
res_rdy  out  1  high when a bank is free
out_data  out  OUT_WIDTH  rounded/saturated element
out_idx  out  clog2(GROUP_NB) (min 1)  element index 0..GROUP_NB-1
out_last  out  1  high with element GROUP_NB-1
out_val  out  1  output element valid
out_rdy  in  1  downstream accept
ovf  out  1  sticky: capture dropped
ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (rst low, any time, mid-stream included): count=0, wr_ptr=0, rd_ptr=0, idx=0, ovf=0. Outputs: out_val=0, out_data=0, out_idx=0, out_last=0, res_rdy=1. Bank contents are not reset.
- res_rdy = (count<2). It depends on registered state only; there is no combinational path from out_rdy.
- Capture: res_val & res_rdy at edge t writes res into bank[wr_ptr], toggles wr_ptr and increments count.
- Capture refused: res_val & !res_rdy drops the data, sets ovf, and leaves banks, pointers and count unchanged.
- out_val = (count!=0). A capture at edge t into an empty buffer gives out_val=1 with element 0 in cycle t+1 (latency 1).
- out_data = sat(round(bank[rd_ptr][idx])) combinationally from registers; forced to 0 when out_val=0. out_idx=idx; out_last=(idx==GROUP_NB-1)&out_val.
- Transfer = out_val & out_rdy.
  - Transfer with idx<GROUP_NB-1: idx increments.
  - Transfer with idx==GROUP_NB-1: idx goes to 0, rd_ptr toggles, count decrements.
- Simultaneous capture and last-element transfer in the same cycle: count unchanged, both pointers toggle. When count==2 that cycle, res_rdy is already low and the capture is refused (ovf sets).
- out_val must stay asserted and out_data/out_idx must stay stable while out_val & !out_rdy (AXI-style hold).
- Arithmetic: treat the result as signed RES_W. If SHIFT>0, add 2^(SHIFT-1) in RES_W+1 bits, then arithmetic shift right by SHIFT (round-half-up). Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- ovf_clr clears ovf. If ovf_clr and a new drop occur in the same cycle, set wins.
- GROUP_NB=1: every element is last.
- States are implied by count: EMPTY (0), ONE (1), FULL (2), plus idx 0..GROUP_NB-1 within the read bank.

Decomposition:
- Package group_pkg: RES_W function of IMG/KER widths, clog2 helper, and the saturation limit constants derived from OUT_WIDTH.
- One sub-module, round_sat (RES_W in, OUT_WIDTH out, SHIFT param), purely combinational. The buffer, counters and handshake stay in group_result_drain.

Test Plan:
- Single capture, out_rdy=1, results {4736, -384, 2^24, -2^24}, SHIFT=8, OUT_WIDTH=16 -> out_val from cycle t+1. Four beats, out_data 19, -1, 32767, -32768 (0x0013, 0xFFFF, 0x7FFF, 0x8000); out_idx 0..3; out_last on beat 3 only.
- Back-pressure: out_rdy toggled 1,0,0,1,... -> no element lost or duplicated; data/idx stable during stalls; exactly 4 transfers per capture.
- Three captures back-to-back with out_rdy=0 -> first two accepted, res_rdy=0 after the second. Third is dropped and ovf=1. With out_rdy=1, 8 elements drain in capture order, then ovf_clr -> ovf=0.
- Capture exactly on the last-element transfer with count=1 -> accepted; next bank's element 0 appears the following cycle with no bubble.
- Assert rst mid-stream (idx=2, count=2) -> asynchronously out_val=0, res_rdy=1, ovf=0. After release, a new capture streams from idx 0.
- SHIFT=0, OUT_WIDTH=16, result 40000 -> 32767; result -5 -> -5.
